// File: rtl/dmem_arb_pkg.sv
// Shared types and constants for the data-memory arbiter.
// Port ids double as round-robin pointer values.
package dmem_arb_pkg;

    localparam int unsigned DEF_ADDR_W = 10;
    localparam int unsigned DEF_DATA_W = 16;

    localparam logic CORE = 1'b0;
    localparam logic AUX  = 1'b1;

    typedef enum logic {
        RR,
        AUX_BURST
    } arb_state_e;

endpackage

// File: rtl/dmem_arbiter_if.sv
// Bus bundle between the two requesters, the arbiter and the single-port dmem.
// The arbiter takes the slave view; requesters and memory take the master view.
interface dmem_arbiter_if #(
    parameter int unsigned ADDR_W = dmem_arb_pkg::DEF_ADDR_W,
    parameter int unsigned DATA_W = dmem_arb_pkg::DEF_DATA_W
);
    logic              core_req;
    logic              core_we;
    logic [ADDR_W-1:0] core_addr;
    logic [DATA_W-1:0] core_wdata;
    logic              core_gnt;
    logic              core_rvalid;
    logic [DATA_W-1:0] core_rdata;

    logic              aux_req;
    logic              aux_we;
    logic [ADDR_W-1:0] aux_addr;
    logic [DATA_W-1:0] aux_wdata;
    logic              aux_lock;
    logic              aux_gnt;
    logic              aux_rvalid;
    logic [DATA_W-1:0] aux_rdata;

    logic              mem_en;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;

    modport slave (
        input  core_req, core_we, core_addr, core_wdata,
        output core_gnt, core_rvalid, core_rdata,
        input  aux_req, aux_we, aux_addr, aux_wdata, aux_lock,
        output aux_gnt, aux_rvalid, aux_rdata,
        output mem_en, mem_we, mem_addr, mem_wdata,
        input  mem_rdata
    );

    modport master (
        output core_req, core_we, core_addr, core_wdata,
        input  core_gnt, core_rvalid, core_rdata,
        output aux_req, aux_we, aux_addr, aux_wdata, aux_lock,
        input  aux_gnt, aux_rvalid, aux_rdata,
        input  mem_en, mem_we, mem_addr, mem_wdata,
        output mem_rdata
    );

endinterface

// File: rtl/dmem_arbiter.sv
// Round-robin arbiter sharing one synchronous-read dmem between core and aux,
// with an aux burst lock and a core starvation guard.
module dmem_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int unsigned ADDR_W    = DEF_ADDR_W,
    parameter int unsigned DATA_W    = DEF_DATA_W,
    parameter int unsigned BURST_MAX = 4,
    parameter int unsigned MAX_WAIT  = 3
) (
    input  logic           clk,
    input  logic           reset,
    dmem_arbiter_if.slave  bus
);

    localparam int unsigned BURST_W = $clog2(BURST_MAX + 1);
    localparam int unsigned WAIT_W  = $clog2(MAX_WAIT + 1);
    localparam logic [BURST_W-1:0] BURST_LIM = BURST_W'(BURST_MAX);
    localparam logic [WAIT_W-1:0]  WAIT_LIM  = WAIT_W'(MAX_WAIT);

    arb_state_e         r_state,       w_state_next;
    logic               r_rr_ptr,      w_rr_ptr_next;
    logic [BURST_W-1:0] r_burst_cnt,   w_burst_cnt_next;
    logic [WAIT_W-1:0]  r_core_wait,   w_core_wait_next;
    logic               r_core_rvalid, w_core_rvalid_next;
    logic               r_aux_rvalid,  w_aux_rvalid_next;

    logic               w_core_gnt;
    logic               w_aux_gnt;
    logic [BURST_W-1:0] w_burst_inc;
    logic [ADDR_W-1:0]  w_mem_addr;
    logic [DATA_W-1:0]  w_mem_wdata;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state       <= RR;
            r_rr_ptr      <= CORE;
            r_burst_cnt   <= '0;
            r_core_wait   <= '0;
            r_core_rvalid <= 1'b0;
            r_aux_rvalid  <= 1'b0;
        end else begin
            r_state       <= w_state_next;
            r_rr_ptr      <= w_rr_ptr_next;
            r_burst_cnt   <= w_burst_cnt_next;
            r_core_wait   <= w_core_wait_next;
            r_core_rvalid <= w_core_rvalid_next;
            r_aux_rvalid  <= w_aux_rvalid_next;
        end
    end

    always_comb begin
        w_state_next     = r_state;
        w_rr_ptr_next    = r_rr_ptr;
        w_burst_cnt_next = r_burst_cnt;
        w_burst_inc      = r_burst_cnt + 1'b1;

        if (w_core_gnt) begin
            w_rr_ptr_next = AUX;
        end else if (w_aux_gnt) begin
            w_rr_ptr_next = CORE;
        end

        case (r_state)
            RR: begin
                // With BURST_MAX == 1 the first locked grant already exhausts the burst.
                if (w_aux_gnt && bus.aux_lock) begin
                    w_burst_cnt_next = BURST_W'(1);
                    if (BURST_MAX > 1) begin
                        w_state_next = AUX_BURST;
                    end
                end
            end
            AUX_BURST: begin
                if (w_core_gnt || !bus.aux_lock) begin
                    w_state_next     = RR;
                    w_burst_cnt_next = '0;
                end else if (w_aux_gnt) begin
                    if (w_burst_inc == BURST_LIM) begin
                        w_state_next     = RR;
                        w_burst_cnt_next = '0;
                    end else begin
                        w_burst_cnt_next = w_burst_inc;
                    end
                end
            end
            default: w_state_next = RR;
        endcase

        w_core_wait_next = r_core_wait;
        if (!bus.core_req || w_core_gnt) begin
            w_core_wait_next = '0;
        end else if (r_core_wait != WAIT_LIM) begin
            w_core_wait_next = r_core_wait + 1'b1;
        end

        w_core_rvalid_next = w_core_gnt && !bus.core_we;
        w_aux_rvalid_next  = w_aux_gnt && !bus.aux_we;
    end

    always_comb begin
        w_core_gnt = 1'b0;
        w_aux_gnt  = 1'b0;
        if (!reset) begin
            if (bus.core_req && bus.aux_req) begin
                if (r_core_wait == WAIT_LIM) begin
                    w_core_gnt = 1'b1;
                end else if (r_state == AUX_BURST && bus.aux_lock) begin
                    w_aux_gnt = 1'b1;
                end else if (r_rr_ptr == CORE) begin
                    w_core_gnt = 1'b1;
                end else begin
                    w_aux_gnt = 1'b1;
                end
            end else begin
                w_core_gnt = bus.core_req;
                w_aux_gnt  = bus.aux_req;
            end
        end

        bus.mem_en  = w_core_gnt || w_aux_gnt;
        bus.mem_we  = 1'b0;
        w_mem_addr  = '0;
        w_mem_wdata = '0;
        if (w_core_gnt) begin
            bus.mem_we  = bus.core_we;
            w_mem_addr  = bus.core_addr;
            w_mem_wdata = bus.core_wdata;
        end else if (w_aux_gnt) begin
            bus.mem_we  = bus.aux_we;
            w_mem_addr  = bus.aux_addr;
            w_mem_wdata = bus.aux_wdata;
        end
        bus.mem_addr  = w_mem_addr;
        bus.mem_wdata = w_mem_wdata;

        bus.core_gnt = w_core_gnt;
        bus.aux_gnt  = w_aux_gnt;

        // Responses in flight when reset rises are dropped, not delivered.
        bus.core_rvalid = r_core_rvalid && !reset;
        bus.aux_rvalid  = r_aux_rvalid && !reset;
        bus.core_rdata  = bus.core_rvalid ? bus.mem_rdata : '0;
        bus.aux_rdata   = bus.aux_rvalid ? bus.mem_rdata : '0;
    end

endmodule

// File: doc/dmem_arbiter.md
# dmem_arbiter

- Shares the single-port 1024×16 data memory between two requesters:
  - the processor load/store stage (core port);
  - an auxiliary master (aux port), e.g. a program/data loader or debug DMA.
- Arbitration is round-robin, with:
  - an optional aux burst lock;
  - a core starvation guard.
- Sits between the processor's memory-stage signals and `dmem`.
- Read data returns one cycle after grant, matching `dmem`'s synchronous read.

## Interface
Parameters:
- ADDR_W, 10, word address width (1024 words)
- DATA_W, 16, data width
- BURST_MAX, 4, max consecutive aux grants under lock (≥1)
- MAX_WAIT, 3, core wait cycles before forced core grant (≥1)

Ports:
- clk  in  1  single clock, rising edge
- reset  in  1  synchronous, active-high
- core_req  in  1  core access request
- core_we  in  1  1 = write, 0 = read
- core_addr  in  ADDR_W  word address
- core_wdata  in  DATA_W  write data
- core_gnt  out  1  request accepted this cycle
- core_rvalid  out  1  read data valid
- core_rdata  out  DATA_W  read data, 0 when core_rvalid low
- aux_req, aux_we, aux_addr, aux_wdata, aux_gnt, aux_rvalid, aux_rdata: same as core_*
- aux_lock  in  1  aux requests back-to-back priority
- mem_en  out  1  memory access strobe
- mem_we  out  1  memory write enable
- mem_addr  out  ADDR_W  memory address
- mem_wdata  out  DATA_W  memory write data
- mem_rdata  in  DATA_W  memory read data, valid one cycle after a read strobe

## Operation
- Requester holds req/we/addr/wdata stable until it sees gnt. The transfer completes on the gnt cycle.
- At most one gnt per cycle. mem_* mirror the granted port. When no grant, mem_en = mem_we = 0 and mem_addr/mem_wdata = 0.
- Read grant → that port's rvalid = 1 next cycle, rdata = mem_rdata. Writes produce no rvalid.
- State machine, 2 states:
  - RR — plain round-robin.
  - AUX_BURST — aux lock active.
- Grant decision when both ports request, highest rule first:
  1. core_wait == MAX_WAIT → core.
  2. AUX_BURST and aux_lock = 1 → aux.
  3. Otherwise rr_ptr decides; rr_ptr = 0 means core first.
- Single requester → granted unconditionally. This applies in either state.
- rr_ptr after any grant points to the other port.
- RR → AUX_BURST:
  - when aux is granted with aux_lock = 1;
  - burst_cnt set to 1.
- AUX_BURST behaviour:
  - each aux grant increments burst_cnt;
  - aux grant with burst_cnt reaching BURST_MAX → RR, rr_ptr = core;
  - aux_lock low, or any core grant → RR.
- core_wait:
  - increments when core_req & !core_gnt, saturating at MAX_WAIT;
  - cleared on core_gnt or core_req = 0.

## Timing
- gnt and mem_* are combinational from req inputs and registered state. There is no request-to-memory register stage.
- Read latency: grant cycle N → rvalid/rdata at cycle N+1. Back-to-back reads sustain 1 per cycle.
- Reset values, synchronous: state = RR, rr_ptr = core, burst_cnt = 0, core_wait = 0, core_rvalid = aux_rvalid = 0.
- While reset is high: both gnt = 0 and mem_en = 0.
- Reset asserted the cycle after a read grant: that rvalid is suppressed and the response is dropped.
- Simultaneous first requests after reset → core wins, because rr_ptr = core.
- BURST_MAX = 1: a locked aux grant returns immediately to RR with rr_ptr = core.
- Starvation bound: with both ports continuously requesting, core waits at most MAX_WAIT cycles.

## Structure
- Package dmem_arb_pkg holds:
  - state enum {RR, AUX_BURST};
  - ADDR_W/DATA_W defaults;
  - port-id constants (CORE = 0, AUX = 1).
- Single module with no sub-module. The grant pick, counters and response routing are small enough to keep flat.

## Test plan
- Reset, then core read addr 5 (mem[5] = 16'h1234) → core_gnt same cycle, core_rvalid = 1 and core_rdata = 16'h1234 next cycle, aux_rvalid = 0.
- Both request continuously, no lock → grants alternate core, aux, core, aux. First grant is core.
- aux_lock = 1 with both requesting, BURST_MAX = 4, MAX_WAIT = 8 → core grant on cycle 1, then 4 consecutive aux grants, then core.
- aux_lock = 1 with both requesting, BURST_MAX = 8, MAX_WAIT = 3 → core_wait reaches 3 and core is granted after 3 aux grants. State returns to RR.
- aux write addr 100 = 16'hBEEF, then core read addr 100 next cycle → core_rdata = 16'hBEEF. No rvalid for the write.
- Core read granted, reset asserted the following cycle → core_rvalid stays 0. Both gnt = 0 during reset. After release, first simultaneous request is granted to core.
